nibble_frame_rx: RTL
====================

// Module: nibble_frame_rx
// PURPOSE
// Serial frame receiver sitting directly upstream of the 4-bit enabled load register.
// - Decodes framed serial input: start bit, DATA_W data bits LSB-first, optional parity bit, stop bit.
// - Drives the register's D input from d_out.
// - Drives the register's clock-enable input from load_en, which is a 1-cycle pulse per good frame.
// - Bad frames never produce load_en, so the downstream register holds its previous value.
// PARAMETERS
// DATA_W      4   data bits per frame; legal 1..16
// PARITY_EN   1   1 = parity bit follows data; 0 = no parity bit
// ODD_PARITY  0   0 = even parity (data XOR parity == 0); 1 = odd parity (== 1)
// PORTS
// clk         in   1        rising-edge clock, shared with the downstream register
// rst         in   1        synchronous, active-high reset
// bit_tick    in   1        1-cycle strobe marking the sample point of each serial bit
// rx_in       in   1        serial line; idles high; sampled only when bit_tick=1
// d_out       out  DATA_W   last good frame's data; feeds register D
// load_en     out  1        1-cycle pulse, good frame complete; feeds register enable
// parity_err  out  1        1-cycle pulse, frame dropped because of a parity mismatch
// frame_err   out  1        1-cycle pulse, frame dropped because stop bit sampled low
// busy        out  1        1 while state != IDLE
// BEHAVIOUR
// Reset: when rst=1 at a clk edge:
// - state=IDLE, shift reg=0, bit count=0.
// - d_out=0, load_en=0, parity_err=0, frame_err=0, busy=0.
// - rst has priority over all other inputs.
// - Reset mid-frame aborts the frame silently: no pulses are emitted.
// Every cycle with bit_tick=0: no state change, and all pulse outputs return to 0.
// FSM (transitions occur only on edges where bit_tick=1):
// - IDLE:   rx_in=0 -> DATA with cnt=0; rx_in=1 -> stay in IDLE.
// - DATA:   shift rx_in into bit[cnt] (LSB first), cnt++.
//           After bit DATA_W-1: go to PARITY if PARITY_EN, else STOP.
// - PARITY: capture the parity bit, then go to STOP.
// - STOP:   evaluate the frame, then go to IDLE.
//   - rx_in=1 and parity OK: d_out <= shift reg, load_en=1.
//   - rx_in=1 and parity bad: parity_err=1; d_out unchanged.
//   - rx_in=0: frame_err=1; d_out unchanged; parity is not reported.
// Timing and latency:
// - Outputs are registered; pulses are high for exactly the one clk cycle after the STOP-tick edge.
// - d_out changes on that same edge.
// - With one tick per cycle, total latency from the start-bit tick edge to load_en high is DATA_W+2+PARITY_EN edges.
// - At most one of load_en, parity_err and frame_err is high in any cycle.
// Start-bit and back-to-back handling:
// - No false-start check: a single low sample in IDLE commits the FSM to a frame.
// - Back-to-back frames are legal: a start bit on the tick immediately after STOP is accepted,
//   because IDLE is re-entered on the STOP edge.
// bit_tick held high continuously: each cycle is treated as one bit, and the FSM must not skip or repeat states.
// cnt width: $clog2(DATA_W+1) bits; cnt never exceeds DATA_W-1 while in DATA.
// STRUCTURE
// Shared package nibble_rx_pkg holds:
// - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t
// - localparams START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1
// One sub-module, serial_shift_in:
// - DATA_W-wide LSB-first shift register plus bit counter, with shift_en/clr inputs and a done flag.
// - The FSM, parity check and output registers stay in the top module.
// TESTING (defaults DATA_W=4, PARITY_EN=1, ODD_PARITY=0; bit_tick every cycle unless stated)
// 1. Good frame, start 0, data 1,0,1,1 (LSB first), parity 1, stop 1 -> d_out=4'b1101, load_en high 1 cycle, no errors.
// 2. Same frame with parity 0 -> parity_err pulse, load_en stays 0, d_out keeps its previous value.
// 3. Good data and parity, stop=0 -> frame_err pulse only, d_out unchanged, FSM back in IDLE, busy=0.
// 4. rst=1 asserted after the 2nd data bit, then a full good frame for 4'hA -> no pulse during the aborted frame, then d_out=4'hA with one load_en.
// 5. Two back-to-back good frames 4'h3 then 4'hC, with bit_tick every 3rd cycle -> exactly two load_en pulses, d_out 3 then C.
// 6. PARITY_EN=0 build, frame for 4'hF -> load_en pulse DATA_W+2 tick-edges after the start edge, d_out=4'hF.

Source files
------------

// File: rtl/nibble_rx_pkg.sv
// Shared types and line levels for the nibble frame receiver.
package nibble_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/serial_shift_in.sv
// LSB-first shift-in register with bit counter.
module serial_shift_in #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              din,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [CW-1:0] cnt;

  assign done = shift_en && (cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (cnt == CW'(i)) data[i] <= din;
      end
      // wrap on the last bit so cnt stays within 0..DATA_W-1
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nibble_frame_rx.sv
// Framed serial receiver feeding a load-enabled register.
module nibble_frame_rx
  import nibble_rx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_tick,
  input  logic              rx_in,
  output logic [DATA_W-1:0] d_out,
  output logic              load_en,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  rx_state_t         state_q, state_d;
  logic              clr, shift_en, done;
  logic              par_q, par_ok;
  logic [DATA_W-1:0] sh_data;

  serial_shift_in #(.DATA_W(DATA_W)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (shift_en),
    .din      (rx_in),
    .data     (sh_data),
    .done     (done)
  );

  assign par_ok = !PARITY_EN ||
                  ((^{sh_data, par_q}) == ODD_PARITY);
  assign busy   = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    clr      = 1'b0;
    shift_en = 1'b0;
    if (bit_tick) begin
      unique case (state_q)
        IDLE: begin
          if (rx_in == START_LVL) begin
            state_d = DATA;
            clr     = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (done) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      par_q      <= 1'b0;
      d_out      <= '0;
      load_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      load_en    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_tick) begin
        state_q <= state_d;
        if (state_q == PARITY) par_q <= rx_in;
        if (state_q == STOP) begin
          if (rx_in != STOP_LVL) begin
            frame_err <= 1'b1;
          end else if (par_ok) begin
            d_out   <= sh_data;
            load_en <= 1'b1;
          end else begin
            parity_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule
